// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the Q16 filter chain stages.
//   Q16_FRAC    : number of fractional bits in the filter's sample format
//   dec_state_t : decimator phase, decoded from the sample counter
//   acc_width   : width of an exact accumulator of n samples of a given width
//   sat_signed  : clip a signed value into the range of an out_width signed word
package fir_pkg;

    localparam int Q16_FRAC = 16;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DUMP  = 1'b1
    } dec_state_t;

    // Summing n signed samples needs $clog2(n) extra bits to stay exact.
    function automatic int acc_width(input int width, input int n);
        return width + $clog2(n);
    endfunction

    // Result is still 64 bits wide; the caller keeps the low out_width bits.
    // Comparing the result with the input tells whether clipping happened.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int out_width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// fir_decimator_if
//   Sample stream between two stages.
//   data  : sample word, W bits
//   valid : producer has a sample on data this cycle
//   ready : consumer accepts this cycle
//   Handshake: a transfer happens on a rising clk edge where valid && ready.
//   While valid is high and ready is low the producer holds data stable.
//   A consumer that can never stall drives ready to constant 1.
interface fir_decimator_if #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo
//   First-word-fall-through FIFO, single clock.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data; ignored when full unless a pop happens too
//   push_data  : W-bit write word
//   pop        : remove the head; ignored when empty
//   pop_data   : current head word, valid whenever empty is low
//   full/empty : occupancy flags
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator
//   Integrate-and-dump decimator behind the FIR filter. Every DECIM valid
//   input samples are summed exactly, divided by DECIM with an arithmetic
//   shift (floor), clipped to OUT_WIDTH and queued in a FWFT FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   in_if     : input stream (slave); ready is tied high, the filter is never stalled
//   out_if    : output stream (master); data is the FIFO head, valid = not empty
//   flush     : drop the partial group, including a sample offered this cycle
//   clr_ovf   : clear the overflow flag
//   sat_event : 1-cycle pulse after pushing (or dropping) a clipped result
//   overflow  : sticky, a result was dropped because the FIFO was full
//   dbg_state : decimator phase (ACCUM / DUMP)
module fir_decimator
    import fir_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    fir_decimator_if.slave    in_if,
    fir_decimator_if.master   out_if,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              sat_event,
    output logic              overflow,
    output dec_state_t        dbg_state
);

    localparam int ACC_W = acc_width(WIDTH, DECIM);
    localparam int SHIFT = $clog2(DECIM);
    localparam int CNT_W = SHIFT;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic        [CNT_W-1:0] cnt;
    logic        [CNT_W-1:0] cnt_nxt;
    dec_state_t              state;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] avg;
    logic signed [63:0]      avg64;
    logic signed [63:0]      sat64;
    logic [OUT_WIDTH-1:0]    res;
    logic                    clipped;
    logic                    push;
    logic                    drop;
    logic                    fifo_full;
    logic                    fifo_empty;

    // The input stage cannot stall the filter.
    assign in_if.ready = 1'b1;

    // The counter is the state register; the last slot of a group is DUMP.
    assign state     = (cnt == CNT_W'(DECIM - 1)) ? ST_DUMP : ST_ACCUM;
    assign dbg_state = state;

    assign in_ext = {{(ACC_W - WIDTH){in_if.data[WIDTH-1]}}, in_if.data};
    assign sum    = acc + in_ext;
    assign avg    = sum >>> SHIFT;
    assign avg64  = {{(64 - ACC_W){avg[ACC_W-1]}}, avg};
    assign sat64  = sat_signed(avg64, OUT_WIDTH);
    assign clipped = (sat64 != avg64);
    assign res    = sat64[OUT_WIDTH-1:0];

    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        push    = 1'b0;
        // flush wins over DUMP so a flushed group never produces a result.
        if (flush) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end else if (in_if.valid) begin
            case (state)
                ST_ACCUM: begin
                    acc_nxt = sum;
                    cnt_nxt = cnt + CNT_W'(1);
                end
                ST_DUMP: begin
                    push    = 1'b1;
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end
                default: begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Full never coexists with empty, so a pop request here is a real pop.
    assign drop = push && fifo_full && !out_if.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sat_event <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            sat_event <= push && clipped;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .W     (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (res),
        .pop       (out_if.ready),
        .pop_data  (out_if.data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.valid = !fifo_empty;

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator
//   Directed checks of fir_decimator with DECIM=4, OUT_WIDTH=16, FIFO_DEPTH=4.
module tb_fir_decimator;
    import fir_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       clr_ovf;
    logic       sat_event;
    logic       overflow;
    dec_state_t dbg_state;

    int checks;
    int errors;

    fir_decimator_if #(.W(32)) in_if ();
    fir_decimator_if #(.W(16)) out_if ();

    fir_decimator #(
        .WIDTH      (32),
        .OUT_WIDTH  (16),
        .DECIM      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_if),
        .out_if    (out_if),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .sat_event (sat_event),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        in_if.data  = d;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_group(input logic [31:0] d);
        for (int i = 0; i < 4; i++) send(d, 0);
    endtask

    task automatic pop_one();
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_if.valid); end
        checks++; if (out_if.data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_if.data); end
        checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_event); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_if.ready); end
        checks++; if (dbg_state !== ST_ACCUM) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_if.ready = 1'b1;
        send(32'd1, 0);
        send(32'd2, 0);
        send(32'd3, 0);
        checks++; if (dbg_state !== ST_DUMP) begin errors++; $display("FAIL basic_state: got %0d expected 1", dbg_state); end
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", out_if.valid); end
        send(32'd4, 0);
        checks++; if (out_if.valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_if.valid); end
        checks++; if (out_if.data !== 16'd2) begin errors++; $display("FAIL basic_data: got %h expected 0002", out_if.data); end
        checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b expected 0", sat_event); end
        tick();
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b expected 0", out_if.valid); end
        out_if.ready = 1'b0;
    endtask

    task automatic test_negative();
        send(-32'sd1, 0);
        send(-32'sd2, 0);
        send(-32'sd3, 0);
        send(-32'sd4, 0);
        checks++; if (out_if.data !== 16'hFFFD) begin errors++; $display("FAIL neg_data: got %h expected fffd", out_if.data); end
        pop_one();
        send(-32'sd1, $urandom_range(0, 3));
        send(-32'sd2, $urandom_range(0, 3));
        send(-32'sd3, $urandom_range(0, 3));
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL neg_gap_early: got %b expected 0", out_if.valid); end
        send(-32'sd4, 0);
        checks++; if (out_if.data !== 16'hFFFD) begin errors++; $display("FAIL neg_gap_data: got %h expected fffd", out_if.data); end
        pop_one();
    endtask

    task automatic test_saturation();
        send_group(32'h0010_0000);
        checks++; if (out_if.data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_data: got %h expected 7fff", out_if.data); end
        checks++; if (sat_event !== 1'b1) begin errors++; $display("FAIL sat_pos_event: got %b expected 1", sat_event); end
        pop_one();
        checks++; if (sat_event !== 1'b0) begin errors++; $display("FAIL sat_pulse: got %b expected 0", sat_event); end
        send_group(-32'sh0010_0000);
        checks++; if (out_if.data !== 16'h8000) begin errors++; $display("FAIL sat_neg_data: got %h expected 8000", out_if.data); end
        checks++; if (sat_event !== 1'b1) begin errors++; $display("FAIL sat_neg_event: got %b expected 1", sat_event); end
        pop_one();
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 4; k++) send_group(32'(k));
        checks++; if (out_if.data !== 16'd1) begin errors++; $display("FAIL ovf_head: got %h expected 0001", out_if.data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
        send_group(32'd5);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        send(32'd6, 0);
        send(32'd6, 0);
        send(32'd6, 0);
        clr_ovf = 1'b1;
        send(32'd6, 0);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        out_if.ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_if.data !== 16'(k)) begin errors++; $display("FAIL ovf_drain: got %h expected %h", out_if.data, 16'(k)); end
            tick();
        end
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", out_if.valid); end
        out_if.ready = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 1; k <= 4; k++) send_group(32'(k));
        send(32'd9, 0);
        send(32'd9, 0);
        send(32'd9, 0);
        out_if.ready = 1'b1;
        send(32'd9, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
        checks++; if (out_if.data !== 16'd2) begin errors++; $display("FAIL fpp_head: got %h expected 0002", out_if.data); end
        tick();
        checks++; if (out_if.data !== 16'd3) begin errors++; $display("FAIL fpp_d3: got %h expected 0003", out_if.data); end
        tick();
        checks++; if (out_if.data !== 16'd4) begin errors++; $display("FAIL fpp_d4: got %h expected 0004", out_if.data); end
        tick();
        checks++; if (out_if.data !== 16'd9) begin errors++; $display("FAIL fpp_d9: got %h expected 0009", out_if.data); end
        tick();
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b expected 0", out_if.valid); end
        out_if.ready = 1'b0;
    endtask

    task automatic test_flush();
        send(32'd100, 0);
        send(32'd100, 0);
        flush = 1'b1;
        send(32'd100, 0);
        flush = 1'b0;
        send(32'd4, 0);
        send(32'd4, 0);
        send(32'd4, 0);
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL flush_early: got %b expected 0", out_if.valid); end
        send(32'd4, 0);
        checks++; if (out_if.data !== 16'd4) begin errors++; $display("FAIL flush_data: got %h expected 0004", out_if.data); end
        pop_one();
        // flush on the group's last slot must not push
        send(32'd5, 0);
        send(32'd5, 0);
        send(32'd5, 0);
        flush = 1'b1;
        send(32'd5, 0);
        flush = 1'b0;
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL flush_dump: got %b expected 0", out_if.valid); end
        send_group(32'd8);
        checks++; if (out_if.data !== 16'd8) begin errors++; $display("FAIL flush_next: got %h expected 0008", out_if.data); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        send_group(32'd6);
        send_group(32'd7);
        send(32'd50, 0);
        send(32'd50, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_if.valid); end
        send(32'd12, 0);
        send(32'd12, 0);
        send(32'd12, 0);
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_early: got %b expected 0", out_if.valid); end
        send(32'd12, 0);
        checks++; if (out_if.data !== 16'd12) begin errors++; $display("FAIL rstmid_data: got %h expected 000c", out_if.data); end
        pop_one();
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_single: got %b expected 0", out_if.valid); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        clr_ovf      = 1'b0;
        in_if.data   = '0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
